// File: rtl/iob_counter_capture_if.sv
`default_nettype none
// ============================================================================
// Module  : iob_counter_capture_if
// Brief   : Consumer-side stream bundle of iob_counter_capture (FIFO head + status).
// Revision: 1.0
// ============================================================================
interface iob_counter_capture_if #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2
);
  logic [DATA_W-1:0]   data_o;
  logic                valid_o;
  logic                ready_i;
  logic [DEPTH_LOG2:0] level_o;
  logic                overflow_o;

  modport master (
    output data_o,
    output valid_o,
    output level_o,
    output overflow_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  level_o,
    input  overflow_o,
    output ready_i
  );
endinterface
`default_nettype wire

// File: rtl/iob_counter_capture.sv
`default_nettype none
// ============================================================================
// Module  : iob_counter_capture
// Brief   : Controls an iob_counter and captures its value on triggers into a
//           small FIFO drained over valid/ready. Optional macro
//           IOB_COUNTER_CAPTURE_DELTA_EN stores inter-capture deltas instead.
// Revision: 1.0
// ============================================================================
module iob_counter_capture #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  wire logic              clk_i,
  input  wire logic              cke_i,
  input  wire logic              arst_n_i,
  input  wire logic              rst_i,
  input  wire logic              start_i,
  input  wire logic              stop_i,
  input  wire logic              trig_i,
  input  wire logic [DATA_W-1:0] cnt_i,
  output logic                   cnt_en_o,
  output logic                   cnt_rst_o,
  iob_counter_capture_if.master  cap_if
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH[DEPTH_LOG2:0];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  cnt_rst_q, cnt_rst_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  trig_ok;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [DATA_W-1:0]     push_word;

  always_comb begin
    state_d    = state_q;
    cnt_rst_d  = 1'b0;
    trig_ok    = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;

    // stop has priority over start
    if (stop_i) begin
      state_d = ST_IDLE;
    end else if (start_i) begin
      state_d = ST_RUN;
    end
    cnt_rst_d = start_i && !stop_i;

    trig_ok = trig_i && (state_q == ST_RUN);
    pop     = valid_q && ready_q_w();
    push    = trig_ok && ((level_q != FULL_LVL) || pop);
    drop    = trig_ok && !push;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    valid_d = (level_d != '0);

    overflow_d = start_i ? 1'b0 : (overflow_q | drop);
  end

  function automatic logic ready_q_w();
    return cap_if.ready_i;
  endfunction

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_rst_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        state_q    <= ST_IDLE;
        cnt_rst_q  <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        valid_q    <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_rst_q  <= cnt_rst_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        level_q    <= level_d;
        valid_q    <= valid_d;
        overflow_q <= overflow_d;
      end
    end
  end

  // Storage needs no reset: a slot is only visible once valid_q covers it.
  always_ff @(posedge clk_i) begin
    if (cke_i && !rst_i && push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

`ifdef IOB_COUNTER_CAPTURE_DELTA_EN
  logic [DATA_W-1:0] prev_q;
  logic              first_q;

  assign push_word = first_q ? cnt_i : (cnt_i - prev_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prev_q  <= '0;
      first_q <= 1'b1;
    end else if (cke_i) begin
      if (rst_i || start_i) begin
        prev_q  <= '0;
        first_q <= 1'b1;
      end else if (push) begin
        prev_q  <= cnt_i;
        first_q <= 1'b0;
      end
    end
  end
`else
  assign push_word = cnt_i;
`endif

  assign cnt_en_o          = (state_q == ST_RUN);
  assign cnt_rst_o         = cnt_rst_q;
  assign cap_if.data_o     = valid_q ? mem_q[rd_ptr_q] : '0;
  assign cap_if.valid_o    = valid_q;
  assign cap_if.level_o    = level_q;
  assign cap_if.overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_counter_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_iob_counter_capture
// Brief   : Scoreboard bench for iob_counter_capture (absolute or delta build).
// Revision: 1.0
// ============================================================================
module tb_iob_counter_capture;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic              clk = 1'b0;
  logic              cke = 1'b1;
  logic              arst_n = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              trig = 1'b0;
  logic [DATA_W-1:0] cnt = '0;
  logic              cnt_en;
  logic              cnt_rst;

  iob_counter_capture_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) cap_if ();

  iob_counter_capture #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk_i    (clk),
    .cke_i    (cke),
    .arst_n_i (arst_n),
    .rst_i    (rst),
    .start_i  (start),
    .stop_i   (stop),
    .trig_i   (trig),
    .cnt_i    (cnt),
    .cnt_en_o (cnt_en),
    .cnt_rst_o(cnt_rst),
    .cap_if   (cap_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic              run_m   = 1'b0;
  logic              ovf_m   = 1'b0;
  logic              rst_m   = 1'b0;
  logic              first_m = 1'b1;
  logic [DATA_W-1:0] prev_m  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle: inputs already applied, model updated, outputs checked after the edge.
  task automatic tick(input string tag);
    logic              pop_m;
    logic [DATA_W-1:0] w;
    if (cke) begin
      if (rst) begin
        q.delete();
        run_m = 1'b0; ovf_m = 1'b0; rst_m = 1'b0; first_m = 1'b1; prev_m = '0;
      end else begin
        pop_m = (q.size() != 0) && cap_if.ready_i;
        if (pop_m) chk({tag, "/pop_data"}, cap_if.data_o, q.pop_front());
        if (run_m && trig) begin
          if (q.size() < DEPTH) begin
`ifdef IOB_COUNTER_CAPTURE_DELTA_EN
            w = first_m ? cnt : cnt - prev_m;
`else
            w = cnt;
`endif
            q.push_back(w);
            first_m = 1'b0;
            prev_m  = cnt;
          end else begin
            ovf_m = 1'b1;
          end
        end
        if (start) begin ovf_m = 1'b0; first_m = 1'b1; end
        rst_m = start && !stop;
        if (stop) run_m = 1'b0;
        else if (start) run_m = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/level"},    cap_if.level_o,    q.size());
    chk({tag, "/valid"},    cap_if.valid_o,    q.size() != 0);
    chk({tag, "/overflow"}, cap_if.overflow_o, ovf_m);
    chk({tag, "/cnt_en"},   cnt_en,            run_m);
    chk({tag, "/cnt_rst"},  cnt_rst,           rst_m);
    if (q.size() != 0) chk({tag, "/head"}, cap_if.data_o, q[0]);
  endtask

  task automatic drive(input logic st, input logic sp, input logic tr,
                       input logic [DATA_W-1:0] cv, input logic rdy, input string tag);
    start = st; stop = sp; trig = tr; cnt = cv; cap_if.ready_i = rdy;
    tick(tag);
  endtask

  initial begin
    cap_if.ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst/data", cap_if.data_o, 0);
    arst_n = 1'b1;
    @(negedge clk);
    chk("reset/cnt_en",   cnt_en, 0);
    chk("reset/cnt_rst",  cnt_rst, 0);
    chk("reset/data",     cap_if.data_o, 0);
    chk("reset/valid",    cap_if.valid_o, 0);
    chk("reset/level",    cap_if.level_o, 0);
    chk("reset/overflow", cap_if.overflow_o, 0);

    // start pulse, then run
    drive(1, 0, 0, 32'd0, 0, "start");
    drive(0, 0, 0, 32'd0, 0, "run1");
    drive(0, 0, 0, 32'd1, 0, "run2");

    // captures at 5, 9, 20 with consumer stalled, then drain
    drive(0, 0, 1, 32'd5,  0, "cap5");
    drive(0, 0, 0, 32'd6,  0, "gap");
    drive(0, 0, 1, 32'd9,  0, "cap9");
    drive(0, 0, 1, 32'd20, 0, "cap20");
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'd21, 1, "drain");

    // overflow: five triggers into depth four
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 32'd30 + i, 0, "ovf");
    drive(1, 0, 0, 32'd35, 0, "restart");
    drive(0, 0, 0, 32'd0, 0, "post_restart");

    // full FIFO, push and pop in the same cycle
    drive(0, 0, 1, 32'd40, 1, "fullpp");

    // clock enable low freezes everything
    cke = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 32'd50, 1, "cke_off");
    cke = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 32'd51, 1, "drain2");

    // simultaneous start/stop goes idle; idle triggers ignored
    drive(1, 1, 0, 32'd60, 0, "startstop");
    drive(0, 0, 1, 32'd77, 0, "idle_trig");
    drive(1, 0, 1, 32'd78, 0, "start_trig");

    // wrap across the counter boundary
    drive(0, 0, 1, 32'hFFFF_FFFE, 0, "wrap_a");
    drive(0, 0, 1, 32'h0000_0001, 0, "wrap_b");
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 32'd2, 1, "drain3");

    // async reset with two words queued
    drive(0, 0, 1, 32'd100, 0, "pre_arst_a");
    drive(0, 0, 1, 32'd101, 0, "pre_arst_b");
    #2 arst_n = 1'b0;
    #1;
    chk("arst/level",  cap_if.level_o, 0);
    chk("arst/valid",  cap_if.valid_o, 0);
    chk("arst/cnt_en", cnt_en, 0);
    q.delete();
    run_m = 1'b0; ovf_m = 1'b0; rst_m = 1'b0; first_m = 1'b1; prev_m = '0;
    @(negedge clk);
    arst_n = 1'b1;
    drive(0, 0, 1, 32'd102, 0, "post_arst");

    // synchronous clear
    drive(1, 0, 0, 32'd0, 0, "start2");
    drive(0, 0, 1, 32'd7, 0, "cap7");
    rst = 1'b1;
    drive(0, 0, 1, 32'd8, 0, "sync_rst");
    rst = 1'b0;
    drive(0, 0, 0, 32'd9, 0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
